// File: rtl/gt_cap_pkg.sv
// Shared types and constants for the GT RX capture block.
package gt_cap_pkg;
   localparam int GT_LANES  = 6;
   localparam int GT_WORD_W = 32;
   localparam int GT_ADDR_W = 8;
   localparam int GT_DATA_W = GT_LANES * GT_WORD_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;
endpackage

// File: rtl/gt_rx_capture_if.sv
// Register-side read port of the capture buffers.
interface gt_rx_capture_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [3:0]        rd_idx;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;

   modport master (output rd_en, rd_addr, rd_idx, input  rd_data, rd_valid);
   modport slave  (input  rd_en, rd_addr, rd_idx, output rd_data, rd_valid);
endinterface

// File: rtl/gt_cap_ram.sv
// One lane buffer: simple dual-port RAM, synchronous write, registered read-first read.
module gt_cap_ram #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);
   logic [WORD_W-1:0] mem_q [2**ADDR_W];
   logic [WORD_W-1:0] rdata_q;

   // Write and read share one block so a same-address access returns the old word.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/gt_rx_capture.sv
// GT RX capture: arms on request, stores LANES x 2**ADDR_W words starting at the
// trigger beat, then serves single-word reads with one cycle of latency.
// Optional lane-0 pattern trigger enabled by defining GT_RX_CAP_TRIG_EN; otherwise
// the first valid beat after arming starts the capture.
module gt_rx_capture
   import gt_cap_pkg::*;
#(
   parameter int LANES  = GT_LANES,
   parameter int WORD_W = GT_WORD_W,
   parameter int ADDR_W = GT_ADDR_W
) (
   input  logic                    gt_clk,
   input  logic                    gt_rstb,
   input  logic [LANES*WORD_W-1:0] gt_rx_data,
   input  logic                    gt_rx_valid,
   input  logic                    cap_arm,
   input  logic                    cap_reset,
   input  logic [ADDR_W-1:0]       cap_last,
   input  logic [WORD_W-1:0]       trig_pattern,
   input  logic [WORD_W-1:0]       trig_mask,
   gt_rx_capture_if.slave          rd,
   output logic                    cap_busy,
   output logic                    cap_done,
   output logic [ADDR_W:0]         cap_count
);
   cap_state_t        state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we;
   logic              trig_hit;
   logic [3:0]        rd_sel_q;
   logic              rd_valid_q;
   logic [WORD_W-1:0] ram_q [LANES];
   logic [WORD_W-1:0] rd_mux;

`ifdef GT_RX_CAP_TRIG_EN
   assign trig_hit = gt_rx_valid &&
                     (((gt_rx_data[WORD_W-1:0] ^ trig_pattern) & trig_mask) == '0);
`else
   logic unused_trig;
   assign unused_trig = ^{trig_pattern, trig_mask};
   assign trig_hit    = gt_rx_valid;
`endif

   // Capture FSM next state; cap_reset overrides every other request.
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      last_d    = last_q;
      count_d   = count_q;
      we        = 1'b0;
      if (cap_reset) begin
         state_d   = IDLE;
         wr_addr_d = '0;
         count_d   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (cap_arm) begin
                  state_d   = ARMED;
                  wr_addr_d = '0;
                  count_d   = '0;
               end
            end
            ARMED: begin
               if (trig_hit) begin
                  we        = 1'b1;
                  last_d    = cap_last;
                  wr_addr_d = wr_addr_q + 1'b1;
                  count_d   = count_q + 1'b1;
                  state_d   = (cap_last == '0) ? DONE : CAPTURE;
               end
            end
            CAPTURE: begin
               if (gt_rx_valid) begin
                  we        = 1'b1;
                  wr_addr_d = wr_addr_q + 1'b1;
                  count_d   = count_q + 1'b1;
                  if (wr_addr_q == last_q) state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Capture FSM registers.
   always_ff @(posedge gt_clk or negedge gt_rstb) begin
      if (!gt_rstb) begin
         state_q   <= IDLE;
         wr_addr_q <= '0;
         last_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         last_q    <= last_d;
         count_q   <= count_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      gt_cap_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_ram (
         .clk_i   (gt_clk),
         .we_i    (we),
         .waddr_i (wr_addr_q),
         .wdata_i (gt_rx_data[g*WORD_W +: WORD_W]),
         .re_i    (rd.rd_en),
         .raddr_i (rd.rd_addr),
         .rdata_o (ram_q[g])
      );
   end

   // Lane select travels with the RAM read; all-ones after reset forces rd_data to 0.
   always_ff @(posedge gt_clk or negedge gt_rstb) begin
      if (!gt_rstb) begin
         rd_sel_q   <= 4'hF;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd.rd_en;
         if (rd.rd_en) rd_sel_q <= rd.rd_idx;
      end
   end

   // Output lane mux; out-of-range lane selects read as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < LANES; i++) begin
         if (rd_sel_q == 4'(i)) rd_mux = ram_q[i];
      end
   end

   assign rd.rd_data  = rd_mux;
   assign rd.rd_valid = rd_valid_q;
   assign cap_busy    = (state_q == ARMED) || (state_q == CAPTURE);
   assign cap_done    = (state_q == DONE);
   assign cap_count   = count_q;
endmodule

// File: tb/tb_gt_rx_capture.sv
// Self-checking bench for gt_rx_capture: table-driven reads scored through a queue,
// plus directed capture sequences. Works with or without GT_RX_CAP_TRIG_EN.
module tb_gt_rx_capture;
   logic         clk = 1'b0;
   logic         rstb = 1'b0;
   logic [191:0] rx_data = '0;
   logic         rx_valid = 1'b0;
   logic         cap_arm = 1'b0;
   logic         cap_reset = 1'b0;
   logic [7:0]   cap_last = '0;
   logic [31:0]  trig_pattern = '0;
   logic [31:0]  trig_mask = '0;
   logic         cap_busy, cap_done;
   logic [8:0]   cap_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [7:0]  addr;
      logic [3:0]  idx;
      logic [31:0] exp;
   } rd_vec_t;
   rd_vec_t vt[$];

   gt_rx_capture_if #(.ADDR_W(8), .WORD_W(32)) rif ();

   gt_rx_capture dut (
      .gt_clk       (clk),
      .gt_rstb      (rstb),
      .gt_rx_data   (rx_data),
      .gt_rx_valid  (rx_valid),
      .cap_arm      (cap_arm),
      .cap_reset    (cap_reset),
      .cap_last     (cap_last),
      .trig_pattern (trig_pattern),
      .trig_mask    (trig_mask),
      .rd           (rif),
      .cap_busy     (cap_busy),
      .cap_done     (cap_done),
      .cap_count    (cap_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lw(input logic [31:0] base, input int sh, input int i, input int k);
      return base | (32'(i) << sh) | 32'(k);
   endfunction

   function automatic logic [191:0] mk(input logic [31:0] base, input int sh, input int k);
      logic [191:0] d;
      for (int i = 0; i < 6; i++) d[i*32 +: 32] = lw(base, sh, i, k);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [191:0] d);
      rx_valid = v;
      rx_data  = d;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic arm();
      cap_arm = 1'b1;
      tick();
      cap_arm = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [3:0] idx, input logic [31:0] e);
      rif.rd_en   = 1'b1;
      rif.rd_addr = a;
      rif.rd_idx  = idx;
      exp_q.push_back(e);
      tick();
      rif.rd_en = 1'b0;
   endtask

   task automatic run_table();
      for (int n = 0; n < vt.size(); n++) begin
         rif.rd_en   = 1'b1;
         rif.rd_addr = vt[n].addr;
         rif.rd_idx  = vt[n].idx;
         exp_q.push_back(vt[n].exp);
         tick();
      end
      rif.rd_en = 1'b0;
      vt.delete();
      tick();
   endtask

   // Read scoreboard: every rd_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rstb && rif.rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_spurious got rd_valid=1 with rd_data 0x%08h want no read pending", rif.rd_data);
         end else begin
            chk("rd_data", rif.rd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [191:0] d;
      rif.rd_en   = 1'b0;
      rif.rd_addr = '0;
      rif.rd_idx  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk) rstb = 1'b1;
      tick();
      chk("rst_busy", 32'(cap_busy), 0);
      chk("rst_done", 32'(cap_done), 0);
      chk("rst_count", 32'(cap_count), 0);
      chk("rst_rd_valid", 32'(rif.rd_valid), 0);
      chk("rst_rd_data", rif.rd_data, 0);

      // Test 1: basic capture, cap_last=3
      cap_last = 8'd3;
      arm();
      chk("t1_busy_armed", 32'(cap_busy), 1);
      for (int b = 0; b < 4; b++) begin
         beat(1'b1, mk(32'hA000_0000, 8, b));
         if (b == 0) chk("t1_count_first", 32'(cap_count), 1);
      end
      chk("t1_done", 32'(cap_done), 1);
      chk("t1_busy", 32'(cap_busy), 0);
      chk("t1_count", 32'(cap_count), 4);
      rd(8'd1, 4'd2, 32'hA000_0201);
      tick();
      chk("t1_rd_valid_idle", 32'(rif.rd_valid), 0);
      for (int a = 0; a < 4; a++)
         for (int i = 0; i < 7; i++)
            vt.push_back('{addr: 8'(a), idx: 4'(i), exp: (i < 6) ? lw(32'hA000_0000, 8, i, a) : 32'h0});
      run_table();

`ifdef GT_RX_CAP_TRIG_EN
      // Test 2: lane-0 pattern trigger
      cap_last     = 8'd1;
      trig_pattern = 32'h1234_5678;
      trig_mask    = 32'hFFFF_0000;
      arm();
      d = mk(32'hF000_0000, 8, 0); d[31:0] = 32'h0000_0000;
      beat(1'b1, d);
      chk("t2_no_trig_count", 32'(cap_count), 0);
      chk("t2_no_trig_busy", 32'(cap_busy), 1);
      d = mk(32'hF000_0000, 8, 1); d[31:0] = 32'h1234_ABCD;
      beat(1'b1, d);
      chk("t2_trig_count", 32'(cap_count), 1);
      d = mk(32'hF000_0000, 8, 2); d[31:0] = 32'h5555_5555;
      beat(1'b1, d);
      chk("t2_done", 32'(cap_done), 1);
      chk("t2_count", 32'(cap_count), 2);
      vt.push_back('{addr: 8'd0, idx: 4'd0, exp: 32'h1234_ABCD});
      vt.push_back('{addr: 8'd0, idx: 4'd1, exp: lw(32'hF000_0000, 8, 1, 1)});
      vt.push_back('{addr: 8'd1, idx: 4'd0, exp: 32'h5555_5555});
      run_table();
      trig_mask = '0;
`endif

      // Test 3: gaps in valid during capture; cap_last change after trigger ignored
      cap_last = 8'd7;
      arm();
      beat(1'b1, mk(32'hB000_0000, 8, 0));
      cap_last = 8'd2;
      for (int k = 1; k < 8; k++) begin
         beat(1'b0, mk(32'hDEAD_0000, 8, k));
         if (k == 3) chk("t3_count_gap", 32'(cap_count), 3);
         beat(1'b1, mk(32'hB000_0000, 8, k));
         if (k == 6) chk("t3_busy_mid", 32'(cap_busy), 1);
      end
      chk("t3_done", 32'(cap_done), 1);
      chk("t3_count", 32'(cap_count), 8);
      for (int a = 0; a < 8; a++) begin
         vt.push_back('{addr: 8'(a), idx: 4'd0, exp: lw(32'hB000_0000, 8, 0, a)});
         vt.push_back('{addr: 8'(a), idx: 4'd5, exp: lw(32'hB000_0000, 8, 5, a)});
      end
      run_table();

      // Test 4: abort mid-capture, arm coincident with reset
      cap_last = 8'd20;
      arm();
      for (int k = 0; k < 5; k++) beat(1'b1, mk(32'hD000_0000, 8, k));
      chk("t4_count5", 32'(cap_count), 5);
      cap_reset = 1'b1;
      tick();
      cap_reset = 1'b0;
      chk("t4_busy", 32'(cap_busy), 0);
      chk("t4_done", 32'(cap_done), 0);
      chk("t4_count", 32'(cap_count), 0);
      cap_arm   = 1'b1;
      cap_reset = 1'b1;
      tick();
      cap_arm   = 1'b0;
      cap_reset = 1'b0;
      chk("t4_arm_rst_busy", 32'(cap_busy), 0);
      beat(1'b1, mk(32'hD000_0000, 8, 9));
      chk("t4_idle_count", 32'(cap_count), 0);

      // Test 5: full-depth capture, no wrap; then single-beat capture with read-first
      cap_last = 8'd255;
      arm();
      for (int k = 0; k < 300; k++) begin
         beat(1'b1, mk(32'hC000_0000, 12, k));
         if (k == 254) chk("t5_busy_255", 32'(cap_busy), 1);
         if (k == 255) begin
            chk("t5_done", 32'(cap_done), 1);
            chk("t5_count", 32'(cap_count), 256);
         end
      end
      chk("t5_done_hold", 32'(cap_done), 1);
      chk("t5_count_hold", 32'(cap_count), 256);
      vt.push_back('{addr: 8'd0,   idx: 4'd0, exp: lw(32'hC000_0000, 12, 0, 0)});
      vt.push_back('{addr: 8'd43,  idx: 4'd5, exp: lw(32'hC000_0000, 12, 5, 43)});
      vt.push_back('{addr: 8'd200, idx: 4'd4, exp: lw(32'hC000_0000, 12, 4, 200)});
      vt.push_back('{addr: 8'd255, idx: 4'd2, exp: lw(32'hC000_0000, 12, 2, 255)});
      run_table();
      cap_last = 8'd0;
      arm();
      chk("t5b_count_armed", 32'(cap_count), 0);
      rif.rd_en   = 1'b1;
      rif.rd_addr = 8'd0;
      rif.rd_idx  = 4'd3;
      exp_q.push_back(lw(32'hC000_0000, 12, 3, 0));
      beat(1'b1, mk(32'hE000_0000, 8, 0));
      rif.rd_en = 1'b0;
      chk("t5b_done", 32'(cap_done), 1);
      chk("t5b_count", 32'(cap_count), 1);
      vt.push_back('{addr: 8'd0, idx: 4'd3, exp: lw(32'hE000_0000, 8, 3, 0)});
      vt.push_back('{addr: 8'd1, idx: 4'd3, exp: lw(32'hC000_0000, 12, 3, 1)});
      run_table();

      // Test 6: out-of-range lane, hold, async reset during a read
      for (int a = 0; a < 4; a++) vt.push_back('{addr: 8'(a), idx: 4'd6, exp: 32'h0});
      run_table();
      rd(8'd0, 4'd3, lw(32'hE000_0000, 8, 3, 0));
      tick();
      chk("t6_valid_low", 32'(rif.rd_valid), 0);
      chk("t6_data_hold", rif.rd_data, lw(32'hE000_0000, 8, 3, 0));
      rif.rd_en   = 1'b1;
      rif.rd_addr = 8'd2;
      rif.rd_idx  = 4'd1;
      #2 rstb = 1'b0;
      #1;
      chk("t6_rst_rd_valid", 32'(rif.rd_valid), 0);
      chk("t6_rst_rd_data", rif.rd_data, 0);
      chk("t6_rst_busy", 32'(cap_busy), 0);
      chk("t6_rst_done", 32'(cap_done), 0);
      chk("t6_rst_count", 32'(cap_count), 0);
      rif.rd_en = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rstb = 1'b1;
      tick();
      chk("t6_post_rst_data", rif.rd_data, 0);
      chk("rd_pending", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
